bp_spi_trace_master: RTL

- Host-side SPI initiator that feeds branch trace records into the perceptron predictor's SPI receiver (cs/mosi/sclk).
- Serializes one {direction, instruction address} record per transaction, releases chip-select, then waits for the predictor's pred_ready pulse and captures the prediction bit.
- Used in the test harness / FPGA companion, and as the stimulus driver in system-level simulation of the predictor.

---
 rtl/bp_spi_trace_master_if.sv | 29 ++
 rtl/bp_spi_trace_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_spi_trace_master_if.sv
// Record, SPI and result signals shared between the trace master and the host/predictor side.
// The master modport is the view taken by bp_spi_trace_master itself.
interface bp_spi_trace_master_if #(
   parameter int ADDR_BITS = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_dir;
   logic [ADDR_BITS-1:0] in_addr;
   logic                 spi_cs_n;
   logic                 spi_sclk;
   logic                 spi_mosi;
   logic                 pred_ready_in;
   logic                 prediction_in;
   logic                 res_valid;
   logic                 res_pred;
   logic                 res_timeout;
   logic                 busy;

   modport master (
      input  in_valid, in_dir, in_addr, pred_ready_in, prediction_in,
      output in_ready, spi_cs_n, spi_sclk, spi_mosi, res_valid, res_pred, res_timeout, busy
   );

   modport slave (
      output in_valid, in_dir, in_addr, pred_ready_in, prediction_in,
      input  in_ready, spi_cs_n, spi_sclk, spi_mosi, res_valid, res_pred, res_timeout, busy
   );
endinterface

// File: rtl/bp_spi_trace_master.sv
// SPI mode-0 initiator: sends one {dir, addr} trace frame MSB first, releases CS,
// then waits a bounded time for the predictor's pred_ready strobe and reports the result.
module bp_spi_trace_master #(
   parameter int ADDR_BITS      = 16,
   parameter int SCLK_DIV       = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   bp_spi_trace_master_if.master    bus
);
   localparam int FRAME_BITS = ADDR_BITS + 1;
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);

   localparam logic [7:0]       DIV_LAST  = 8'(SCLK_DIV - 1);
   localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BITS_DONE = BIT_W'(FRAME_BITS);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_SHIFT     = 3'd2,
      ST_HOLD      = 3'd3,
      ST_WAIT_PRED = 3'd4,
      ST_REPORT    = 3'd5
   } state_t;

   state_t               state_r, state_s;
   logic [7:0]           div_cnt_r, div_cnt_s;
   logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
   logic [15:0]          to_cnt_r, to_cnt_s;
   logic [ADDR_BITS-1:0] shreg_r, shreg_s;
   logic                 sclk_r, sclk_s;
   logic                 mosi_r, mosi_s;
   logic                 res_valid_r, res_valid_s;
   logic                 res_pred_r, res_pred_s;
   logic                 res_timeout_r, res_timeout_s;
   logic                 cs_n_r, in_ready_r, busy_r;
   logic                 accept_s, div_end_s, timeout_s;

   // The direction bit goes straight to mosi at accept; the shift register only holds the address.
   assign accept_s  = (state_r == ST_IDLE) && bus.in_valid && in_ready_r;
   assign div_end_s = (div_cnt_r == DIV_LAST);
   assign timeout_s = (to_cnt_r == TO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_s = ST_SETUP;
            else          state_s = ST_IDLE;
         end
         ST_SETUP: begin
            if (div_end_s) state_s = ST_SHIFT;
            else           state_s = ST_SETUP;
         end
         ST_SHIFT: begin
            if (div_end_s && !sclk_r && (bit_cnt_r == BITS_DONE)) state_s = ST_HOLD;
            else                                                  state_s = ST_SHIFT;
         end
         ST_HOLD: begin
            if (div_end_s) state_s = ST_WAIT_PRED;
            else           state_s = ST_HOLD;
         end
         ST_WAIT_PRED: begin
            if (bus.pred_ready_in || timeout_s) state_s = ST_REPORT;
            else                                state_s = ST_WAIT_PRED;
         end
         ST_REPORT: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      div_cnt_s     = div_cnt_r;
      bit_cnt_s     = bit_cnt_r;
      to_cnt_s      = to_cnt_r;
      shreg_s       = shreg_r;
      sclk_s        = sclk_r;
      mosi_s        = mosi_r;
      res_valid_s   = 1'b0;
      res_pred_s    = res_pred_r;
      res_timeout_s = res_timeout_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               shreg_s   = bus.in_addr;
               mosi_s    = bus.in_dir;
               div_cnt_s = 8'd0;
               bit_cnt_s = '0;
            end else begin
               sclk_s = 1'b0;
               mosi_s = 1'b0;
            end
         end
         ST_SETUP: begin
            if (div_end_s) begin
               div_cnt_s = 8'd0;
               sclk_s    = 1'b1;
            end else begin
               div_cnt_s = div_cnt_r + 8'd1;
            end
         end
         ST_SHIFT: begin
            if (!div_end_s) begin
               div_cnt_s = div_cnt_r + 8'd1;
            end else if (sclk_r) begin
               // Falling edge: present the next bit; zeros shift in, so mosi ends at 0.
               div_cnt_s = 8'd0;
               sclk_s    = 1'b0;
               mosi_s    = shreg_r[ADDR_BITS-1];
               shreg_s   = shreg_r << 1;
               bit_cnt_s = bit_cnt_r + 1'b1;
            end else if (bit_cnt_r == BITS_DONE) begin
               div_cnt_s = 8'd0;
               mosi_s    = 1'b0;
            end else begin
               div_cnt_s = 8'd0;
               sclk_s    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (div_end_s) begin
               div_cnt_s = 8'd0;
               to_cnt_s  = 16'd0;
            end else begin
               div_cnt_s = div_cnt_r + 8'd1;
            end
         end
         ST_WAIT_PRED: begin
            if (bus.pred_ready_in) begin
               res_valid_s   = 1'b1;
               res_pred_s    = bus.prediction_in;
               res_timeout_s = 1'b0;
            end else if (timeout_s) begin
               res_valid_s   = 1'b1;
               res_pred_s    = 1'b0;
               res_timeout_s = 1'b1;
            end else begin
               to_cnt_s = to_cnt_r + 16'd1;
            end
         end
         ST_REPORT: res_valid_s = 1'b0;
         default: begin
            sclk_s = 1'b0;
            mosi_s = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs; handshake flags follow the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r     <= 8'd0;
         bit_cnt_r     <= '0;
         to_cnt_r      <= 16'd0;
         shreg_r       <= '0;
         sclk_r        <= 1'b0;
         mosi_r        <= 1'b0;
         res_valid_r   <= 1'b0;
         res_pred_r    <= 1'b0;
         res_timeout_r <= 1'b0;
         cs_n_r        <= 1'b1;
         in_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
      end else begin
         div_cnt_r     <= div_cnt_s;
         bit_cnt_r     <= bit_cnt_s;
         to_cnt_r      <= to_cnt_s;
         shreg_r       <= shreg_s;
         sclk_r        <= sclk_s;
         mosi_r        <= mosi_s;
         res_valid_r   <= res_valid_s;
         res_pred_r    <= res_pred_s;
         res_timeout_r <= res_timeout_s;
         cs_n_r        <= !((state_s == ST_SETUP) || (state_s == ST_SHIFT));
         in_ready_r    <= (state_s == ST_IDLE);
         busy_r        <= (state_s != ST_IDLE);
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.spi_cs_n    = cs_n_r;
   assign bus.spi_sclk    = sclk_r;
   assign bus.spi_mosi    = mosi_r;
   assign bus.res_valid   = res_valid_r;
   assign bus.res_pred    = res_pred_r;
   assign bus.res_timeout = res_timeout_r;
   assign bus.busy        = busy_r;
endmodule
